leitor_caminho: RTL and testbench
=================================

# leitor_caminho

Downstream stage of the pathfinding core: once a search completes, walks the predecessor ("anterior") memory from destination back to source and streams the resulting path to the host, source first. A LIFO reverses the backward walk. Output uses a valid/ready handshake with a last flag. Sits between the predecessor-memory read port and the external host interface.

## Interface
- ADDR_WIDTH, default `ADDR_WIDTH from defines.vh (12): node address width.
- MAX_CAMINHO, default 256: maximum path length in nodes, which is the LIFO depth.
- Reset is rst_n, asynchronous, active-low. The clock is clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- iniciar_in  in  1  single-cycle start pulse, sampled only in OCIOSO
- fonte_in  in  ADDR_WIDTH  source node, captured with iniciar_in
- destino_in  in  ADDR_WIDTH  destination node, captured with iniciar_in
- mem_rd_en_out  out  1  predecessor memory read strobe
- mem_rd_addr_out  out  ADDR_WIDTH  predecessor memory read address
- mem_rd_data_in  in  ADDR_WIDTH  predecessor of the addressed node, valid exactly 1 cycle after mem_rd_en_out
- caminho_valid_out  out  1  path word valid
- caminho_data_out  out  ADDR_WIDTH  path node
- caminho_ultimo_out  out  1  marks the final node (the destination)
- caminho_ready_in  in  1  host accepts the word
- comprimento_out  out  $clog2(MAX_CAMINHO)+1  node count of the current path, held until the next start
- ocupado_out  out  1  high whenever the FSM is not in OCIOSO
- pronto_out  out  1  one-cycle pulse after the last word is accepted
- erro_out  out  1  overflow; held until the next accepted iniciar_in

## Operation
- States are OCIOSO, EMPILHAR, ESPERA, EMITIR and ERRO.
- **OCIOSO:** on iniciar_in:
  - capture fonte, set cur=destino_in, sp=0, clear erro_out and comprimento_out;
  - go to EMPILHAR.
- **EMPILHAR:**
  - push cur, sp++.
  - If cur==fonte, go to EMITIR.
  - Else if sp (after push) == MAX_CAMINHO, go to ERRO.
  - Else assert mem_rd_en_out with mem_rd_addr_out=cur and go to ESPERA.
- **ESPERA:** cur <= mem_rd_data_in, then go to EMPILHAR.
- **EMITIR:**
  - caminho_valid_out=1 and caminho_data_out=stack[sp-1]. The top of stack is the source, so the path comes out source first.
  - caminho_ultimo_out=(sp==1).
  - On valid&&ready: pop. If sp was 1, pulse pronto_out and go to OCIOSO.
  - Data is held stable while ready is low.
- **ERRO:**
  - erro_out=1, nothing is emitted, the stack is discarded, then go to OCIOSO.
  - erro_out stays high in OCIOSO until the next iniciar_in.
- comprimento_out mirrors sp during the walk and is frozen at the final count on entry to EMITIR.
- iniciar_in outside OCIOSO is ignored.
- fonte==destino gives a single-word path with ultimo=1 and comprimento=1.
- A cycle in the predecessor memory, or an unreachable source, ends in ERRO via overflow and never hangs.

## Timing
- iniciar_in is sampled at cycle 0. Node k (1..N) is pushed in cycle 2k−1.
- First caminho_valid_out is in cycle 2N. With ready held high, one word per cycle, so the last word is at cycle 3N−1 and pronto_out at 3N.
- Read latency is exactly 1 cycle. mem_rd_en_out is high only in EMPILHAR cycles that issue a read, never in the fonte-push cycle.
- Reset values: all outputs 0, the FSM in OCIOSO, sp=0.
- Reset mid-operation aborts immediately, with no pronto_out or erro_out pulse.

## Structure
- ADDR_WIDTH comes from the shared defines.vh. State encodings are local parameters of the module.
- One sub-module, pilha_caminho:
  - a register-array LIFO of depth MAX_CAMINHO;
  - ports push/pop/topo/sp/cheio/vazio and a synchronous clear;
  - simultaneous push and pop are not needed and not supported.
- Top-level wiring:
  - mem_rd_* connects to the predecessor-memory read port;
  - iniciar_in is driven by the construir_caminho indication of the state-machine controller.

## Test plan
- Chain 7→5→2→0, fonte=0, destino=7, ready=1 → words 0,2,5,7 in cycles 8–11; ultimo only on 7; comprimento=4; pronto_out in cycle 12.
- fonte=destino=9 → no memory read, a single word 9 with ultimo=1 in cycle 2, comprimento=1.
- Same chain with ready toggling 1,0,0,1… → no word is lost or duplicated, and data is stable while ready=0.
- MAX_CAMINHO=4 with the loop 3→1→3 and fonte=0 → erro_out=1 after 4 pushes, caminho_valid never asserted; a following valid request recovers normally.
- iniciar_in pulsed during EMITIR → ignored, the current path completes unchanged.
- rst_n asserted in the middle of ESPERA → all outputs 0 asynchronously; after release a fresh iniciar_in runs a full path correctly.

Source files
------------

// File: rtl/leitor_caminho_pkg.sv
// Shared constants for the path reader: default widths and the stack-pointer sizing helper.
package leitor_caminho_pkg;

    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_MAX_CAMINHO = 256;

    // Stack pointer must count 0..profundidade inclusive
    function automatic int largura_sp(input int profundidade);
        return $clog2(profundidade) + 1;
    endfunction

endpackage

// File: rtl/leitor_caminho_pilha_caminho.sv
// pilha_caminho: register-array LIFO holding the backward walk so it can be replayed source first.
module pilha_caminho
    import leitor_caminho_pkg::*;
#(
    parameter int LARGURA     = DEF_ADDR_WIDTH,
    parameter int PROFUNDIDADE = DEF_MAX_CAMINHO
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                srst,
    input  logic                                push,
    input  logic                                pop,
    input  logic [LARGURA-1:0]                  dado,
    output logic [LARGURA-1:0]                  topo,
    output logic [$clog2(PROFUNDIDADE):0]       sp,
    output logic                                cheio,
    output logic                                vazio
);

    localparam int SPW = largura_sp(PROFUNDIDADE);
    localparam int IW  = SPW - 1;
    localparam logic [SPW-1:0] SP_UM   = SPW'(1);
    localparam logic [SPW-1:0] SP_ZERO = SPW'(0);
    localparam logic [SPW-1:0] SP_MAX  = SPW'(PROFUNDIDADE);

    logic [LARGURA-1:0] mem_r [PROFUNDIDADE];
    logic [SPW-1:0]     sp_r;
    logic [IW-1:0]      idx_topo_s;

    assign cheio      = (sp_r == SP_MAX);
    assign vazio      = (sp_r == SP_ZERO);
    assign sp         = sp_r;
    assign idx_topo_s = IW'(sp_r - SP_UM);
    assign topo       = vazio ? {LARGURA{1'b0}} : mem_r[idx_topo_s];

    // Stack pointer: clear wins, push and pop are never requested together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= SP_ZERO;
        end else if (srst) begin
            sp_r <= SP_ZERO;
        end else if (push && !cheio) begin
            sp_r <= sp_r + SP_UM;
        end else if (pop && !vazio) begin
            sp_r <= sp_r - SP_UM;
        end else begin
            sp_r <= sp_r;
        end
    end

    // Storage array; contents above sp are don't-care so it carries no reset
    always_ff @(posedge clk) begin
        if (push && !cheio && !srst) begin
            mem_r[sp_r[IW-1:0]] <= dado;
        end
    end

endmodule

// File: rtl/leitor_caminho.sv
// leitor_caminho: walks the predecessor memory from destination to source and streams the path source first.
module leitor_caminho
    import leitor_caminho_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MAX_CAMINHO = DEF_MAX_CAMINHO
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           iniciar_in,
    input  logic [ADDR_WIDTH-1:0]          fonte_in,
    input  logic [ADDR_WIDTH-1:0]          destino_in,
    output logic                           mem_rd_en_out,
    output logic [ADDR_WIDTH-1:0]          mem_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0]          mem_rd_data_in,
    output logic                           caminho_valid_out,
    output logic [ADDR_WIDTH-1:0]          caminho_data_out,
    output logic                           caminho_ultimo_out,
    input  logic                           caminho_ready_in,
    output logic [$clog2(MAX_CAMINHO):0]   comprimento_out,
    output logic                           ocupado_out,
    output logic                           pronto_out,
    output logic                           erro_out
);

    localparam int SPW = largura_sp(MAX_CAMINHO);
    localparam logic [SPW-1:0] SP_UM  = SPW'(1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(MAX_CAMINHO);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        EMPILHAR = 3'd1,
        ESPERA   = 3'd2,
        EMITIR   = 3'd3,
        ERRO     = 3'd4
    } estado_t;

    estado_t               estado_r, estado_prox_s;
    logic [ADDR_WIDTH-1:0] cur_r, fonte_r;
    logic [SPW-1:0]        comprimento_r;
    logic                  erro_r, pronto_r, rd_en_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic                  push_s, pop_s, limpar_s, rd_en_prox_s;
    logic [ADDR_WIDTH-1:0] rd_addr_prox_s;
    logic [ADDR_WIDTH-1:0] topo_s;
    logic [SPW-1:0]        sp_s, sp_mais_um_s;
    logic                  cheio_s, vazio_s;

    pilha_caminho #(
        .LARGURA      (ADDR_WIDTH),
        .PROFUNDIDADE (MAX_CAMINHO)
    ) u_pilha (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (limpar_s),
        .push  (push_s),
        .pop   (pop_s),
        .dado  (cur_r),
        .topo  (topo_s),
        .sp    (sp_s),
        .cheio (cheio_s),
        .vazio (vazio_s)
    );

    assign sp_mais_um_s       = sp_s + SP_UM;
    assign caminho_valid_out  = (estado_r == EMITIR);
    assign caminho_data_out   = (caminho_valid_out && !vazio_s) ? topo_s : {ADDR_WIDTH{1'b0}};
    assign caminho_ultimo_out = caminho_valid_out && (sp_s == SP_UM);
    assign ocupado_out        = (estado_r != OCIOSO);
    assign mem_rd_en_out      = rd_en_r;
    assign mem_rd_addr_out    = rd_addr_r;
    assign comprimento_out    = comprimento_r;
    assign pronto_out         = pronto_r;
    assign erro_out           = erro_r;

    // Next state, stack control, and the read to issue in the upcoming push cycle
    always_comb begin
        estado_prox_s  = estado_r;
        push_s         = 1'b0;
        pop_s          = 1'b0;
        limpar_s       = 1'b0;
        rd_en_prox_s   = 1'b0;
        rd_addr_prox_s = {ADDR_WIDTH{1'b0}};
        case (estado_r)
            OCIOSO: begin
                if (iniciar_in) begin
                    estado_prox_s = EMPILHAR;
                    limpar_s      = 1'b1;
                    // The destination push reads only if it is not already the source
                    if ((destino_in != fonte_in) && (SP_UM != SP_MAX)) begin
                        rd_en_prox_s   = 1'b1;
                        rd_addr_prox_s = destino_in;
                    end else begin
                        rd_en_prox_s   = 1'b0;
                    end
                end else begin
                    estado_prox_s = OCIOSO;
                end
            end
            EMPILHAR: begin
                push_s = 1'b1;
                if (cur_r == fonte_r) begin
                    estado_prox_s = EMITIR;
                end else if ((sp_mais_um_s == SP_MAX) || cheio_s) begin
                    estado_prox_s = ERRO;
                end else begin
                    estado_prox_s = ESPERA;
                end
            end
            ESPERA: begin
                estado_prox_s = EMPILHAR;
                if ((mem_rd_data_in != fonte_r) && (sp_mais_um_s != SP_MAX)) begin
                    rd_en_prox_s   = 1'b1;
                    rd_addr_prox_s = mem_rd_data_in;
                end else begin
                    rd_en_prox_s   = 1'b0;
                end
            end
            EMITIR: begin
                if (caminho_ready_in) begin
                    pop_s = 1'b1;
                    if (sp_s == SP_UM) begin
                        estado_prox_s = OCIOSO;
                    end else begin
                        estado_prox_s = EMITIR;
                    end
                end else begin
                    estado_prox_s = EMITIR;
                end
            end
            ERRO: begin
                limpar_s      = 1'b1;
                estado_prox_s = OCIOSO;
            end
            default: begin
                limpar_s      = 1'b1;
                estado_prox_s = OCIOSO;
            end
        endcase
    end

    // State, walk cursor and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r      <= OCIOSO;
            cur_r         <= {ADDR_WIDTH{1'b0}};
            fonte_r       <= {ADDR_WIDTH{1'b0}};
            comprimento_r <= {SPW{1'b0}};
            erro_r        <= 1'b0;
            pronto_r      <= 1'b0;
            rd_en_r       <= 1'b0;
            rd_addr_r     <= {ADDR_WIDTH{1'b0}};
        end else begin
            estado_r  <= estado_prox_s;
            rd_en_r   <= rd_en_prox_s;
            rd_addr_r <= rd_addr_prox_s;
            pronto_r  <= pop_s && (sp_s == SP_UM);
            case (estado_r)
                OCIOSO: begin
                    if (iniciar_in) begin
                        fonte_r       <= fonte_in;
                        cur_r         <= destino_in;
                        erro_r        <= 1'b0;
                        comprimento_r <= {SPW{1'b0}};
                    end
                end
                EMPILHAR: begin
                    comprimento_r <= sp_mais_um_s;
                    if (estado_prox_s == ERRO) begin
                        erro_r <= 1'b1;
                    end
                end
                ESPERA: begin
                    cur_r <= mem_rd_data_in;
                end
                default: begin
                    cur_r <= cur_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leitor_caminho.sv
// Self-checking bench for leitor_caminho: directed scenarios plus random chains against a queue-based path model.
module tb_leitor_caminho;

    localparam int AW   = 12;
    localparam int MAXC = 8;
    localparam int CW   = $clog2(MAXC) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iniciar_in = 1'b0;
    logic [AW-1:0] fonte_in = '0;
    logic [AW-1:0] destino_in = '0;
    logic          mem_rd_en_out;
    logic [AW-1:0] mem_rd_addr_out;
    logic [AW-1:0] mem_rd_data_in = '0;
    logic          caminho_valid_out;
    logic [AW-1:0] caminho_data_out;
    logic          caminho_ultimo_out;
    logic          caminho_ready_in = 1'b0;
    logic [CW-1:0] comprimento_out;
    logic          ocupado_out, pronto_out, erro_out;

    logic [AW-1:0] pred [0:(1<<AW)-1];
    int n_assert = 0;
    int n_fail   = 0;

    leitor_caminho #(.ADDR_WIDTH(AW), .MAX_CAMINHO(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar_in(iniciar_in),
        .fonte_in(fonte_in), .destino_in(destino_in),
        .mem_rd_en_out(mem_rd_en_out), .mem_rd_addr_out(mem_rd_addr_out),
        .mem_rd_data_in(mem_rd_data_in),
        .caminho_valid_out(caminho_valid_out), .caminho_data_out(caminho_data_out),
        .caminho_ultimo_out(caminho_ultimo_out), .caminho_ready_in(caminho_ready_in),
        .comprimento_out(comprimento_out), .ocupado_out(ocupado_out),
        .pronto_out(pronto_out), .erro_out(erro_out)
    );

    always #5 clk = ~clk;

    // Predecessor memory: data valid exactly one cycle after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (mem_rd_en_out) mem_rd_data_in <= pred[mem_rd_addr_out];
        else               mem_rd_data_in <= AW'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Builds a chain of distinct nodes d -> ... ; optionally closes it into a loop that misses the source
    task automatic make_chain(input int len, input bit ciclo, output logic [AW-1:0] f, output logic [AW-1:0] d);
        logic [AW-1:0] nodes [$];
        logic [AW-1:0] base;
        base = AW'($urandom);
        for (int i = 0; i < len; i++) nodes.push_back(base + AW'(i * 37));
        for (int i = 0; i + 1 < len; i++) pred[nodes[i]] = nodes[i+1];
        d = nodes[0];
        if (ciclo) begin
            pred[nodes[len-1]] = nodes[0];
            f = base + AW'(len * 37);
        end else begin
            f = nodes[len-1];
        end
    endtask

    task automatic run_path(input logic [AW-1:0] f, input logic [AW-1:0] d, input int rmode, input bit poke);
        logic [AW-1:0] exp_q [$];
        logic [AW-1:0] cur;
        logic [AW-1:0] prev_data;
        bit exp_err, seen_valid, prev_hold, last_acc, done, r;
        int n, got, cyc, reads;
        // Reference walk: collect nodes back to the source, bounded by the stack depth
        exp_q = {};
        cur = d;
        exp_err = 1'b0;
        while (1) begin
            exp_q.push_front(cur);
            if (cur == f) break;
            if (exp_q.size() == MAXC) begin exp_err = 1'b1; break; end
            cur = pred[cur];
        end
        n = exp_q.size();

        @(negedge clk);
        fonte_in = f; destino_in = d; iniciar_in = 1'b1; caminho_ready_in = 1'b0;
        @(negedge clk);
        iniciar_in = 1'b0;
        chk("busy_after_start", 32'(ocupado_out), 32'd1);
        chk("erro_cleared", 32'(erro_out), 32'd0);
        cyc = 1; got = 0; reads = 0;
        seen_valid = 1'b0; prev_hold = 1'b0; last_acc = 1'b0; done = 1'b0;
        prev_data = '0;
        while (!done && cyc < 4 * MAXC + 20) begin
            if (last_acc) begin
                chk("pronto_pulse", 32'(pronto_out), 32'd1);
                chk("idle_after_path", 32'(ocupado_out), 32'd0);
                chk("comprimento_final", 32'(comprimento_out), 32'(n));
                chk("read_count", 32'(reads), 32'(n - 1));
                chk("valid_after_last", 32'(caminho_valid_out), 32'd0);
                done = 1'b1;
            end else if (erro_out) begin
                chk("erro_expected", 32'(erro_out), 32'(exp_err));
                chk("erro_cycle", 32'(cyc), 32'(2 * n));
                chk("comprimento_erro", 32'(comprimento_out), 32'(MAXC));
                chk("read_count_erro", 32'(reads), 32'(n - 1));
                chk("no_word_on_erro", 32'(seen_valid), 32'd0);
                @(negedge clk);
                chk("idle_after_erro", 32'(ocupado_out), 32'd0);
                chk("erro_held", 32'(erro_out), 32'd1);
                chk("no_pronto_on_erro", 32'(pronto_out), 32'd0);
                done = 1'b1;
            end else begin
                if (mem_rd_en_out) reads++;
                if (cyc <= 2 * n) chk("comprimento_walk", 32'(comprimento_out), 32'(cyc / 2));
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = (cyc < 2 * n) ? 1'b1 : (((cyc - 2 * n) % 3) == 0);
                    default: r = ($urandom_range(0, 3) != 0);
                endcase
                caminho_ready_in = r;
                if (poke && cyc == 2 * n + 1) begin
                    iniciar_in = 1'b1; fonte_in = ~f; destino_in = ~d;
                end else begin
                    iniciar_in = 1'b0;
                end
                if (caminho_valid_out) begin
                    if (!seen_valid) begin
                        chk("first_valid_cycle", 32'(cyc), 32'(2 * n));
                        seen_valid = 1'b1;
                    end
                    if (prev_hold) chk("held_data", 32'(caminho_data_out), 32'(prev_data));
                    if (!exp_err && got < n) begin
                        chk("path_word", 32'(caminho_data_out), 32'(exp_q[got]));
                        chk("ultimo_flag", 32'(caminho_ultimo_out), 32'(got == n - 1));
                    end else begin
                        chk("unexpected_word", 32'(caminho_valid_out), 32'd0);
                    end
                    if (r) begin
                        got++; prev_hold = 1'b0; last_acc = (got == n);
                    end else begin
                        prev_hold = 1'b1; prev_data = caminho_data_out;
                    end
                end else if (prev_hold) begin
                    chk("valid_dropped", 32'(caminho_valid_out), 32'd1);
                    prev_hold = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk("path_completed", 32'(done), 32'd1);
        caminho_ready_in = 1'b0;
        iniciar_in = 1'b0;
    endtask

    task automatic set_demo_chain();
        pred[7] = 12'd5; pred[5] = 12'd2; pred[2] = 12'd0;
    endtask

    initial begin
        logic [AW-1:0] f, d;
        for (int i = 0; i < (1 << AW); i++) pred[i] = AW'($urandom);

        #12;
        chk("rst_ocupado", 32'(ocupado_out), 32'd0);
        chk("rst_valid", 32'(caminho_valid_out), 32'd0);
        chk("rst_data", 32'(caminho_data_out), 32'd0);
        chk("rst_ultimo", 32'(caminho_ultimo_out), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en_out), 32'd0);
        chk("rst_rd_addr", 32'(mem_rd_addr_out), 32'd0);
        chk("rst_comprimento", 32'(comprimento_out), 32'd0);
        chk("rst_pronto", 32'(pronto_out), 32'd0);
        chk("rst_erro", 32'(erro_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        set_demo_chain();
        run_path(12'd0, 12'd7, 0, 1'b0);
        run_path(12'd9, 12'd9, 0, 1'b0);
        run_path(12'd0, 12'd7, 1, 1'b0);

        pred[3] = 12'd1; pred[1] = 12'd3;
        run_path(12'd0, 12'd3, 0, 1'b0);
        run_path(12'd0, 12'd7, 0, 1'b0);
        run_path(12'd0, 12'd7, 0, 1'b1);

        // Reset in the middle of ESPERA
        @(negedge clk);
        fonte_in = 12'd0; destino_in = 12'd7; iniciar_in = 1'b1;
        @(negedge clk);
        iniciar_in = 1'b0;
        @(negedge clk);
        chk("busy_before_reset", 32'(ocupado_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ocupado", 32'(ocupado_out), 32'd0);
        chk("mid_rst_valid", 32'(caminho_valid_out), 32'd0);
        chk("mid_rst_rd_en", 32'(mem_rd_en_out), 32'd0);
        chk("mid_rst_comprimento", 32'(comprimento_out), 32'd0);
        chk("mid_rst_erro", 32'(erro_out), 32'd0);
        chk("mid_rst_pronto", 32'(pronto_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_path(12'd0, 12'd7, 2, 1'b0);

        make_chain(MAXC, 1'b0, f, d);
        run_path(f, d, 0, 1'b0);
        make_chain(1, 1'b1, f, d);
        run_path(f, d, 0, 1'b0);
        for (int k = 0; k < 14; k++) begin
            make_chain($urandom_range(1, MAXC), ($urandom_range(0, 4) == 0), f, d);
            run_path(f, d, 2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
